// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOP
    } state_e;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: period counter, boundary detect, registered waveform and tick.
// Defining CLK_DIV_DUTY50_EN adds a falling-edge stage that gives odd ratios a 50% duty cycle.
module clk_div_core #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] cur_div,
    input  logic         run,
    input  logic         clear,
    output logic         boundary,
    output logic         tick,
    output logic         outclk
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         p_q, p_d;
    logic         tick_q, tick_d;

    // cur_div is never below 2, so the subtraction cannot wrap.
    assign boundary = (cnt_q == cur_div - W'(1));

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d  = '0;
        p_d    = 1'b0;
        tick_d = 1'b0;
        if (run) begin
            cnt_d  = (clear || boundary) ? '0 : cnt_q + W'(1);
            p_d    = (cnt_d < (cur_div >> 1));
            tick_d = (cnt_d == '0);
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            p_q    <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            p_q    <= p_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef CLK_DIV_DUTY50_EN
    logic n_q;

    // Half-cycle extension only for odd ratios; even ratios already sit at 50%.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= 1'b0;
        end else begin
            n_q <= run & p_q & cur_div[0];
        end
    end

    assign outclk = p_q | n_q;
`else
    assign outclk = p_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time divider controller: start/stop FSM, ratio handshake and boundary-aligned ratio changes.
// Build option CLK_DIV_DUTY50_EN (handled in clk_div_core) selects 50% duty for odd ratios.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEF_DIV = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_valid,
    output logic         div_ready,
    output logic         outclk,
    output logic         tick,
    output logic         active,
    output logic [W-1:0] cur_div,
    output logic         err
);

    state_e       state_q, state_d;
    logic [W-1:0] cur_div_q, cur_div_d;
    logic [W-1:0] pend_div_q, pend_div_d;
    logic         err_q, err_d;
    logic         boundary;
    logic         accept;
    logic         legal;
    logic         core_run;
    logic         core_clear;

    assign div_ready = (state_q == IDLE) || (state_q == RUN);
    assign accept    = div_valid && div_ready;
    assign legal     = (div_in >= W'(MIN_DIV));

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        err_d      = accept && !legal;
        unique case (state_q)
            IDLE: begin
                if (accept && legal) cur_div_d = div_in;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (accept && legal) begin
                    // A stop at this very boundary has no period left to wait for.
                    if (!en && boundary) begin
                        cur_div_d = div_in;
                        state_d   = IDLE;
                    end else begin
                        pend_div_d = div_in;
                        state_d    = PEND;
                    end
                end else if (!en) begin
                    state_d = boundary ? IDLE : STOP;
                end
            end
            PEND: begin
                if (boundary) begin
                    cur_div_d = pend_div_q;
                    state_d   = en ? RUN : IDLE;
                end
            end
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_div_q  <= W'(DEF_DIV);
            pend_div_q <= W'(DEF_DIV);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            err_q      <= err_d;
        end
    end

    // The counter restarts from 0 when leaving IDLE and is held cleared whenever IDLE is next.
    assign core_run   = (state_d != IDLE);
    assign core_clear = (state_q == IDLE);

    clk_div_core #(
        .W (W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .cur_div  (cur_div_q),
        .run      (core_run),
        .clear    (core_clear),
        .boundary (boundary),
        .tick     (tick),
        .outclk   (outclk)
    );

    assign active  = (state_q != IDLE);
    assign cur_div = cur_div_q;
    assign err     = err_q;

endmodule
